// File: rtl/uart_frame_unpacker.sv
// Byte-stream frame decoder: SYNC, LEN, LEN*4 payload bytes packed big-endian into
// 32-bit words, then an XOR checksum byte. Bad or timed-out frames end with tuser=1.
module uart_frame_unpacker #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_WORDS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic        frame_error,
    output logic        len_error,
    output logic        timeout_error
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_WORDS);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       csum_q, csum_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [23:0]      asm_q, asm_d;
    logic [31:0]      held_q, held_d;
    logic             held_vld_q, held_vld_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [31:0] tdata_d;
    logic        tvalid_d, tlast_d, tuser_d;
    logic        busy_d, frame_err_d, len_err_d, tmo_err_d;

    logic        out_free, accept, counting, tmo_hit;
    logic [31:0] asm_word;
    logic [7:0]  wcnt_inc;

    // Output register can take a new word this cycle (empty or being drained).
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = rst_n && (state_q != S_FLUSH) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign counting      = ((state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM))
                           && s_axis_tready && !s_axis_tvalid;
    // Fires on the idle cycle that brings the counter to TIMEOUT_CYCLES.
    assign tmo_hit       = counting && (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        asm_d       = asm_q;
        held_d      = held_q;
        held_vld_d  = held_vld_q;
        tmo_d       = tmo_q;
        tdata_d     = m_axis_tdata;
        tvalid_d    = m_axis_tvalid && !m_axis_tready;
        tlast_d     = m_axis_tlast;
        tuser_d     = m_axis_tuser;
        frame_err_d = 1'b0;
        len_err_d   = 1'b0;
        tmo_err_d   = 1'b0;
        asm_word    = {asm_q, s_axis_tdata};
        wcnt_inc    = wcnt_q + 8'd1;

        if (accept) begin
            tmo_d = '0;
        end else if (counting && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (tmo_hit) begin
            // Abort: partial assembly is dropped, a held word closes the frame as bad.
            tmo_err_d = 1'b1;
            tmo_d     = '0;
            state_d   = S_IDLE;
            if (held_vld_q) begin
                if (out_free) begin
                    tdata_d    = held_q;
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b1;
                    tuser_d    = 1'b1;
                    held_vld_d = 1'b0;
                end else begin
                    state_d = S_FLUSH;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (s_axis_tdata == SYNC_BYTE)) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if ((s_axis_tdata == 8'd0) || (s_axis_tdata > MAX_LEN)) begin
                            len_err_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            len_d      = s_axis_tdata;
                            csum_d     = s_axis_tdata;
                            idx_d      = 2'd0;
                            wcnt_d     = 8'd0;
                            held_vld_d = 1'b0;
                            state_d    = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        asm_d  = asm_word[23:0];
                        csum_d = csum_q ^ s_axis_tdata;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (held_vld_q) begin
                                tdata_d  = held_q;
                                tvalid_d = 1'b1;
                                tlast_d  = 1'b0;
                                tuser_d  = 1'b0;
                            end
                            held_d     = asm_word;
                            held_vld_d = 1'b1;
                            wcnt_d     = wcnt_inc;
                            if (wcnt_inc == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        tdata_d     = held_q;
                        tvalid_d    = 1'b1;
                        tlast_d     = 1'b1;
                        tuser_d     = (s_axis_tdata != csum_q);
                        frame_err_d = (s_axis_tdata != csum_q);
                        held_vld_d  = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        tdata_d    = held_q;
                        tvalid_d   = 1'b1;
                        tlast_d    = 1'b1;
                        tuser_d    = 1'b1;
                        held_vld_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            wcnt_q        <= '0;
            asm_q         <= '0;
            held_q        <= '0;
            held_vld_q    <= 1'b0;
            tmo_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            busy          <= 1'b0;
            frame_error   <= 1'b0;
            len_error     <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            csum_q        <= csum_d;
            idx_q         <= idx_d;
            wcnt_q        <= wcnt_d;
            asm_q         <= asm_d;
            held_q        <= held_d;
            held_vld_q    <= held_vld_d;
            tmo_q         <= tmo_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tuser  <= tuser_d;
            busy          <= busy_d;
            frame_error   <= frame_err_d;
            len_error     <= len_err_d;
            timeout_error <= tmo_err_d;
        end
    end

endmodule
